reg_file_sweep: RTL and testbench
=================================

# reg_file_sweep

Parametrised register file for the single-cycle datapath: one synchronous write port, two combinational read ports, configurable width/depth, optional hardwired-zero register 0. Adds a sequenced CLEAR operation that zeroes the array one entry per cycle with a BUSY flag, so software-visible clearing no longer requires a global reset. Sits between instruction decode (addresses, WRITE) and the ALU (OUT1/OUT2 operands, IN result).

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 8, number of registers; power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  asynchronous, active-high reset
- IN  input  WIDTH  write data
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write enable
- OUT1ADDRESS  input  ADDR_W  read address, port 1
- OUT2ADDRESS  input  ADDR_W  read address, port 2
- CLEAR  input  1  request sequenced clear of all registers
- OUT1  output  WIDTH  read data, port 1 (combinational)
- OUT2  output  WIDTH  read data, port 2 (combinational)
- BUSY  output  1  high while clear sweep in progress

## Operation
- RESET high (any time, independent of CLK): all registers 0, state IDLE, sweep pointer 0, BUSY 0; holds while RESET high. Aborts a sweep in progress.
- Reads: OUTn = register[OUTnADDRESS], combinational, no clock involvement; with ZERO_REG=1 address 0 reads 0.
- Write: at rising edge in IDLE with WRITE=1, register[INADDRESS] <= IN. With ZERO_REG=1, writes to address 0 dropped.
- FSM states IDLE, SWEEP.
- IDLE -> SWEEP: rising edge with CLEAR=1; pointer <= 0; a WRITE sampled at that same edge is still performed.
- SWEEP: each edge register[pointer] <= 0, pointer <= pointer+1. At edge where pointer == DEPTH-1 (clearing last entry): pointer wraps to 0, state <= IDLE.
- In SWEEP: WRITE ignored (no register change); CLEAR ignored (no restart, no extension).
- Reads in SWEEP return current contents: already-swept entries 0, others old values.
- BUSY = (state == SWEEP), registered.

## Timing
- Read latency: 0 cycles (combinational from address and array).
- Write latency: data visible on OUTn immediately after the capturing edge.
- CLEAR at edge E: BUSY high from E through E+DEPTH, low after edge E+DEPTH; register k zeroed at edge E+1+k; all zero after edge E+DEPTH; writes accepted again at edge E+DEPTH+1.
- Minimum CLEAR-to-CLEAR spacing: DEPTH+1 edges.
- Simultaneous WRITE + CLEAR in IDLE: write lands at E, is overwritten by sweep at E+1+INADDRESS.
- RESET deassertion: first active edge is the next rising CLK edge; state IDLE.

## Configuration
- Macro REG_FILE_SWEEP_BYPASS_EN.
- Defined: write-read forwarding. When WRITE=1, state IDLE, and OUTnADDRESS == INADDRESS (excluding address 0 when ZERO_REG=1), OUTn = IN combinationally in the cycle before the edge. No forwarding during SWEEP.
- Not defined: OUTn always reflects stored array; new value appears only after the write edge.

## Test plan
- Reset: pulse RESET mid-cycle with registers holding 0xA5 -> OUT1/OUT2 = 0x00 immediately, BUSY 0, without a CLK edge.
- Write/read: write 0x3C to r5, 0xF0 to r2; set OUT1ADDRESS=5, OUT2ADDRESS=2 -> OUT1=0x3C, OUT2=0xF0 same cycle; ZERO_REG=1 write 0x77 to r0 -> OUT1 (addr 0) = 0x00.
- Sweep: fill r0..r7 with 0x11..0x88, assert CLEAR one cycle -> BUSY high 8 cycles; r3 reads 0x44 until edge E+4 then 0x00; all zero after E+8.
- Collisions: WRITE r1=0x99 during SWEEP -> r1 unchanged/0; CLEAR during SWEEP -> BUSY still drops after exactly 8 cycles; WRITE r6=0x55 with CLEAR in IDLE -> r6 = 0x55 until E+7, then 0x00.
- Reset mid-sweep: RESET at sweep cycle 3 -> all registers 0, BUSY 0 at once; write r4=0x2A next edge accepted.
- Bypass (macro defined): WRITE=1, INADDRESS=OUT1ADDRESS=7, IN=0xC3, r7=0x00 -> OUT1=0xC3 before edge; macro undefined -> OUT1=0x00 until edge.

Source files
------------

// File: rtl/reg_file_sweep_if.sv
// Register-file access bundle: write port, two read ports, clear request and busy status.
// The read data lines are combinational outputs of the register file (suffix _c).
interface reg_file_sweep_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              clear;
    logic [WIDTH-1:0]  rdata1_c;
    logic [WIDTH-1:0]  rdata2_c;
    logic              busy;

    modport master (
        output wdata, waddr, we, raddr1, raddr2, clear,
        input  rdata1_c, rdata2_c, busy
    );

    modport slave (
        input  wdata, waddr, we, raddr1, raddr2, clear,
        output rdata1_c, rdata2_c, busy
    );
endinterface

// File: rtl/reg_file_sweep.sv
// Register file with 1 write / 2 combinational read ports and a one-entry-per-cycle CLEAR sweep.
// Define REG_FILE_SWEEP_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_sweep #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reg_file_sweep_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              busy_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              wr_ok_c;
    logic [WIDTH-1:0]  rd1_c;
    logic [WIDTH-1:0]  rd2_c;

    // Writes to the hardwired-zero entry are dropped at the source.
    assign wr_ok_c = bus.we && !(ZERO_REG && (bus.waddr == '0));
    assign ptr_d   = ptr_q + ADDR_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_ok_c) begin
                        mem_q[bus.waddr] <= bus.wdata;
                    end
                    if (bus.clear) begin
                        state_q <= ST_SWEEP;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // WRITE and CLEAR are ignored until the last entry is cleared.
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_d;
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd1_c = mem_q[bus.raddr1];
        rd2_c = mem_q[bus.raddr2];
        if (ZERO_REG && (bus.raddr1 == '0)) rd1_c = '0;
        if (ZERO_REG && (bus.raddr2 == '0)) rd2_c = '0;
`ifdef REG_FILE_SWEEP_BYPASS_EN
        if ((state_q == ST_IDLE) && wr_ok_c && (bus.raddr1 == bus.waddr)) rd1_c = bus.wdata;
        if ((state_q == ST_IDLE) && wr_ok_c && (bus.raddr2 == bus.waddr)) rd2_c = bus.wdata;
`else
`endif
    end

    assign bus.rdata1_c = rd1_c;
    assign bus.rdata2_c = rd2_c;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reg_file_sweep.sv
// Testbench for reg_file_sweep: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus and are
// compared every cycle against an array model that tracks the clear sweep as a countdown.
module tb_reg_file_sweep;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned VW     = 2 * (2 * WIDTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              we_d    = 1'b0;
    logic              clear_d = 1'b0;
    logic [ADDR_W-1:0] waddr_d = '0;
    logic [ADDR_W-1:0] ra1_d   = '0;
    logic [ADDR_W-1:0] ra2_d   = '0;
    logic [WIDTH-1:0]  wdata_d = '0;

    reg_file_sweep_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus0 ();
    reg_file_sweep_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus1 ();

    assign bus0.we = we_d;       assign bus1.we = we_d;
    assign bus0.waddr = waddr_d; assign bus1.waddr = waddr_d;
    assign bus0.wdata = wdata_d; assign bus1.wdata = wdata_d;
    assign bus0.clear = clear_d; assign bus1.clear = clear_d;
    assign bus0.raddr1 = ra1_d;  assign bus1.raddr1 = ra1_d;
    assign bus0.raddr2 = ra2_d;  assign bus1.raddr2 = ra2_d;

    reg_file_sweep #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    reg_file_sweep #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] m0 [DEPTH];
    logic [WIDTH-1:0] m1 [DEPTH];
    int sweep_left = 0;

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        sweep_left = 0;
    endfunction

    // One rising edge: a pending sweep clears the next entry, otherwise accept write/clear.
    function automatic void model_edge();
        if (sweep_left > 0) begin
            m0[DEPTH - sweep_left] = '0;
            m1[DEPTH - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (we_d) begin
                m0[waddr_d] = wdata_d;
                if (waddr_d != '0) m1[waddr_d] = wdata_d;
            end
            if (clear_d) sweep_left = DEPTH;
        end
    endfunction

    function automatic logic [WIDTH-1:0] mread(input bit zr, input logic [ADDR_W-1:0] a);
        if (zr && a == '0) return '0;
`ifdef REG_FILE_SWEEP_BYPASS_EN
        if (we_d && sweep_left == 0 && a == waddr_d) return wdata_d;
`endif
        return zr ? m1[a] : m0[a];
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic b;
        b = (sweep_left > 0);
        return {mread(1'b0, ra1_d), mread(1'b0, ra2_d), b,
                mread(1'b1, ra1_d), mread(1'b1, ra2_d), b};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus0.rdata1_c, bus0.rdata2_c, bus0.busy,
                bus1.rdata1_c, bus1.rdata2_c, bus1.busy};
    endfunction

    task automatic drive(input logic we, input int wa, input logic [WIDTH-1:0] wd,
                         input logic cl, input int a1, input int a2);
        we_d    = we;
        waddr_d = ADDR_W'(wa);
        wdata_d = wd;
        clear_d = cl;
        ra1_d   = ADDR_W'(a1);
        ra2_d   = ADDR_W'(a2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_init: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, i, 8'hA5, 1'b0, i, (i + 1) % DEPTH);
            tick();
        end
        drive(1'b0, 0, 8'h00, 1'b0, 3, 6);
        #1;
        vectors++;
        if (bus0.rdata1_c !== 8'hA5 || bus0.rdata2_c !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_prefill: got %h/%h expected a5/a5", bus0.rdata1_c, bus0.rdata2_c);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (bus0.rdata1_c !== 8'h00 || bus0.rdata2_c !== 8'h00 || bus0.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got %h/%h busy %b expected 00/00 busy 0",
                     bus0.rdata1_c, bus0.rdata2_c, bus0.busy);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_async_vec: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        drive(1'b1, 5, 8'h3C, 1'b0, 5, 2);
        tick();
        drive(1'b1, 2, 8'hF0, 1'b0, 5, 2);
        tick();
        drive(1'b0, 0, 8'h00, 1'b0, 5, 2);
        #1;
        vectors++;
        if (bus0.rdata1_c !== 8'h3C || bus0.rdata2_c !== 8'hF0) begin
            miscompares++;
            $display("FAIL write_read: got %h/%h expected 3c/f0", bus0.rdata1_c, bus0.rdata2_c);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL write_read_vec: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b1, 0, 8'h77, 1'b0, 0, 5);
        tick();
        drive(1'b0, 0, 8'h00, 1'b0, 0, 5);
        #1;
        vectors++;
        if (bus1.rdata1_c !== 8'h00 || bus0.rdata1_c !== 8'h77) begin
            miscompares++;
            $display("FAIL zero_reg: got zr1=%h zr0=%h expected zr1=00 zr0=77",
                     bus1.rdata1_c, bus0.rdata1_c);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL zero_reg_vec: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_sweep();
        logic [WIDTH-1:0] r3;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, i, WIDTH'(8'h11 * (i + 1)), 1'b0, i, i);
            tick();
        end
        drive(1'b0, 0, 8'h00, 1'b1, 3, 7);
        tick();
        for (int j = 0; j < 10; j++) begin
            drive(1'b0, 0, 8'h00, 1'b0, 3, int'($urandom_range(0, DEPTH - 1)));
            #1;
            r3 = (j < 4) ? 8'h44 : 8'h00;
            vectors++;
            if ({bus0.rdata1_c, bus0.busy} !== {r3, (j < 8)}) begin
                miscompares++;
                $display("FAIL sweep_r3 j=%0d: got %h busy %b expected %h busy %b",
                         j, bus0.rdata1_c, bus0.busy, r3, (j < 8));
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sweep_vec j=%0d: got %h expected %h", j, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_collisions();
        logic [WIDTH-1:0] r6;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, i, WIDTH'($urandom), 1'b0, i, i);
            tick();
        end
        drive(1'b0, 0, 8'h00, 1'b1, 1, 6);
        tick();
        for (int j = 0; j < 10; j++) begin
            drive(j == 1, 1, 8'h99, (j == 2 || j == 5), 1, 6);
            #1;
            vectors++;
            if (bus0.busy !== (j < 8)) begin
                miscompares++;
                $display("FAIL collide_busy j=%0d: got %b expected %b", j, bus0.busy, (j < 8));
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL collide_vec j=%0d: got %h expected %h", j, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b1, 6, 8'h55, 1'b1, 6, 1);
        tick();
        for (int j = 0; j < 10; j++) begin
            drive(1'b0, 0, 8'h00, 1'b0, 6, int'($urandom_range(0, DEPTH - 1)));
            #1;
            r6 = (j < 7) ? 8'h55 : 8'h00;
            vectors++;
            if (bus0.rdata1_c !== r6) begin
                miscompares++;
                $display("FAIL write_clear_r6 j=%0d: got %h expected %h", j, bus0.rdata1_c, r6);
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL write_clear_vec j=%0d: got %h expected %h", j, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, i, WIDTH'($urandom_range(1, 255)), 1'b0, i, i);
            tick();
        end
        drive(1'b0, 0, 8'h00, 1'b1, 5, 7);
        tick();
        drive(1'b0, 0, 8'h00, 1'b0, 5, 7);
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (bus0.busy !== 1'b0 || bus0.rdata1_c !== 8'h00 || bus0.rdata2_c !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_sweep: got %h/%h busy %b expected 00/00 busy 0",
                     bus0.rdata1_c, bus0.rdata2_c, bus0.busy);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_sweep_vec: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4, 8'h2A, 1'b0, 4, 0);
        tick();
        drive(1'b0, 0, 8'h00, 1'b0, 4, 0);
        #1;
        vectors++;
        if (bus0.rdata1_c !== 8'h2A || bus1.rdata1_c !== 8'h2A) begin
            miscompares++;
            $display("FAIL post_reset_write: got %h/%h expected 2a/2a", bus0.rdata1_c, bus1.rdata1_c);
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] want;
`ifdef REG_FILE_SWEEP_BYPASS_EN
        want = 8'hC3;
`else
        want = 8'h00;
`endif
        drive(1'b1, 7, 8'h00, 1'b0, 7, 7);
        tick();
        drive(1'b1, 7, 8'hC3, 1'b0, 7, 0);
        #1;
        vectors++;
        if (bus0.rdata1_c !== want) begin
            miscompares++;
            $display("FAIL bypass_pre_edge: got %h expected %h", bus0.rdata1_c, want);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL bypass_vec: got %h expected %h", obs_vec(), exp_vec());
        end
        tick();
        drive(1'b0, 0, 8'h00, 1'b0, 7, 0);
        #1;
        vectors++;
        if (bus0.rdata1_c !== 8'hC3) begin
            miscompares++;
            $display("FAIL bypass_post_edge: got %h expected c3", bus0.rdata1_c);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom),
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)));
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random n=%0d: got %h expected %h", n, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_collisions();
        test_reset_mid_sweep();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
